ones_count_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit ones-counting datapath among several requesters. Each requester submits a multi-byte word. The block grants one requester at a time and feeds the word through the shared 8-bit population counter one byte per clock, accumulating the total. It then returns the count, tagged with the requester index, over a valid/ready result port. It sits between the requesting lab blocks and the single ones-counter instance so that counter is never duplicated.

---
 rtl/ones_count_sched.sv | 171 +++++++++++++++++
 tb/tb_ones_count_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_sched.sv
// ones_count_sched: round-robin arbiter in front of a single 8-bit ones counter.
// A granted requester's word is captured into a shift register and is
// popcounted one byte per clock. The total is returned with the requester
// index over a valid/ready result port.
module ones_count_sched #(
    parameter int NREQ  = 4,
    parameter int BYTES = 4,
    localparam int W     = 8 * BYTES,
    localparam int CNT_W = $clog2(8 * BYTES + 1),
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*W-1:0]     req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_W-1:0]      res_count,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy
);

    // The byte counter must hold BYTES-1; the +1 keeps the width non-zero for BYTES=1.
    localparam int BC_W = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ID_W-1:0]   ptr_r;
    logic [W-1:0]      sr_r;
    logic [CNT_W-1:0]  acc_r;
    logic [BC_W-1:0]   bc_r;
    logic [ID_W-1:0]   res_id_r;
    logic [ID_W-1:0]   gnt_id_s;
    logic              gnt_any_s;
    logic              last_byte_s;

    // Ones count of one byte; the result never exceeds 8, so 4 bits suffice.
    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, b[i]};
        end
        return n;
    endfunction

    assign last_byte_s = (bc_r == BC_W'(BYTES - 1));
    assign res_count   = acc_r;
    assign res_id      = res_id_r;

    // Round-robin search: first valid requester at or above ptr, wrapping at NREQ.
    always_comb begin
        int  idx_v;
        logic hit_v;
        gnt_any_s = 1'b0;
        gnt_id_s  = '0;
        idx_v     = 0;
        hit_v     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v     = (int'(ptr_r) + k >= NREQ) ? (int'(ptr_r) + k - NREQ) : (int'(ptr_r) + k);
            hit_v     = !gnt_any_s && req_valid[idx_v];
            gnt_id_s  = hit_v ? ID_W'(idx_v) : gnt_id_s;
            gnt_any_s = gnt_any_s | hit_v;
        end
    end

    // State register; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_nx_s = ST_COUNT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (last_byte_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_COUNT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode; req_ready is gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s && rst_n) begin
                    req_ready[gnt_id_s] = 1'b1;
                end else begin
                    req_ready = '0;
                end
            end
            ST_COUNT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: capture on grant, then accumulate one byte per COUNT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r    <= '0;
            sr_r     <= '0;
            acc_r    <= '0;
            bc_r     <= '0;
            res_id_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_any_s) begin
                        sr_r     <= req_data[int'(gnt_id_s)*W +: W];
                        acc_r    <= '0;
                        bc_r     <= '0;
                        res_id_r <= gnt_id_s;
                        ptr_r    <= (gnt_id_s == ID_W'(NREQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_COUNT: begin
                    acc_r <= acc_r + CNT_W'(popcount8(sr_r[7:0]));
                    sr_r  <= sr_r >> 4'd8;
                    bc_r  <= bc_r + BC_W'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_count_sched.sv
// Directed bench for ones_count_sched. Expected results are queued when a
// request is driven and are popped by a monitor on each result handshake.
module tb_ones_count_sched;

    localparam int NREQ  = 4;
    localparam int BYTES = 4;
    localparam int W     = 32;
    localparam int CNT_W = 6;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*W-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [CNT_W-1:0]     res_count;
    logic [ID_W-1:0]      res_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] words [4];

    ones_count_sched #(.NREQ(NREQ), .BYTES(BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int ones(input logic [31:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance to 2 time units after the next rising edge (safe drive point).
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        req_data[i*W +: W] = w;
    endtask

    task automatic push(input int id, input int cnt);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Wait out COUNT after a grant cycle and check the result cycle.
    task automatic wait_result(input string tag, input logic [31:0] cnt, input logic [31:0] id);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) req_valid = '0;
            #1;
            chk({tag, "_ready"}, req_ready, 4'b0000);
            chk({tag, "_valid"}, res_valid, (k == 5) ? 1'b1 : 1'b0);
            if (k == 5) begin
                chk({tag, "_count"}, res_count, cnt);
                chk({tag, "_id"}, res_id, id);
            end
        end
    endtask

    // Scoreboard monitor: every accepted result must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed id=%0d count=%0d expected no result", res_id, res_count);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_id", res_id, mon_e.id);
                chk("sb_count", res_count, mon_e.cnt);
            end
        end
    end

    initial begin
        logic [3:0] m;
        logic [31:0] bw0;
        logic [31:0] bw1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        words[0]  = 32'h0000_00FF;
        words[1]  = 32'h8000_0001;
        words[2]  = 32'hDEAD_BEEF;
        words[3]  = 32'h1357_9BDF;
        for (int i = 0; i < 4; i++) set_word(i, words[i]);

        // Reset state
        step();
        step();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_count", res_count, 6'd0);
        chk("rst_id", res_id, 2'd0);
        chk("rst_ready", req_ready, 4'b0000);

        // Start a request, then abort it with reset mid-COUNT
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("pre_grant", req_ready, 4'b0001);
        step();
        #1;
        chk("pre_busy", busy, 1'b1);
        chk("pre_ready", req_ready, 4'b0000);
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", res_valid, 1'b0);
        chk("abort_count", res_count, 6'd0);
        chk("abort_id", res_id, 2'd0);
        chk("abort_ready", req_ready, 4'b0000);
        step();
        step();

        // Round-robin with all four requesters continuously valid
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) step();
            if (c % 6 == 0) push((c / 6) % 4, ones(words[(c / 6) % 4]));
            #1;
            m = (c % 6 == 0) ? (4'b0001 << ((c / 6) % 4)) : 4'b0000;
            chk("rr_ready", req_ready, m);
            chk("rr_valid", res_valid, (c % 6 == 5) ? 1'b1 : 1'b0);
        end
        step();
        req_valid = '0;
        #1;
        chk("rr_idle_busy", busy, 1'b0);
        chk("rr_drained", exp_q.size(), 32'd0);

        // Single request from requester 2
        step();
        set_word(2, 32'hF0F0_0F01);
        req_valid = 4'b0100;
        push(2, 13);
        #1;
        chk("single_grant", req_ready, 4'b0100);
        wait_result("single", 32'd13, 32'd2);

        // Skip: ptr is 3, only requester 1 valid
        step();
        set_word(1, 32'hA5A5_0003);
        req_valid = 4'b0010;
        push(1, ones(32'hA5A5_0003));
        #1;
        chk("skip_grant", req_ready, 4'b0010);
        wait_result("skip", 32'd10, 32'd1);

        // Wrap: ptr is 2, only requester 0 valid, all-zero word
        step();
        set_word(0, 32'h0000_0000);
        req_valid = 4'b0001;
        push(0, 0);
        #1;
        chk("wrap_grant", req_ready, 4'b0001);
        wait_result("zero", 32'd0, 32'd0);

        // All-ones word from requester 0
        step();
        set_word(0, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        push(0, 32);
        #1;
        chk("ones_grant", req_ready, 4'b0001);
        wait_result("ones", 32'd32, 32'd0);

        // Backpressure: hold the result for 10 cycles with another requester pending
        bw0 = 32'h1234_5678;
        bw1 = 32'h0F0F_0F0F;
        step();
        res_ready = 1'b0;
        set_word(0, bw0);
        req_valid = 4'b0001;
        push(0, ones(bw0));
        #1;
        chk("bp_grant", req_ready, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) req_valid = '0;
            if (k == 2) begin
                set_word(1, bw1);
                req_valid = 4'b0010;
            end
            #1;
            chk("bp_cnt_valid", res_valid, 1'b0);
        end
        for (int k = 5; k <= 14; k++) begin
            step();
            #1;
            chk("bp_hold_valid", res_valid, 1'b1);
            chk("bp_hold_count", res_count, 6'(ones(bw0)));
            chk("bp_hold_id", res_id, 2'd0);
            chk("bp_hold_ready", req_ready, 4'b0000);
        end
        step();
        res_ready = 1'b1;
        #1;
        chk("bp_release_valid", res_valid, 1'b1);
        step();
        push(1, ones(bw1));
        #1;
        chk("bp_next_grant", req_ready, 4'b0010);
        wait_result("bp2", 32'd16, 32'd1);

        step();
        #1;
        chk("end_busy", busy, 1'b0);
        chk("end_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
